// File: rtl/mips_cpu_bus_muldiv.sv
// rtl/mips_cpu_bus_muldiv.sv - bit-serial MIPS HI/LO multiply/divide unit
module mips_cpu_bus_muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  control_alu,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [4:0] OP_DIVU  = 5'd4;
  localparam logic [4:0] OP_DIV   = 5'd5;
  localparam logic [4:0] OP_MULTU = 5'd7;
  localparam logic [4:0] OP_MULT  = 5'd8;
  localparam logic [4:0] OP_MTLO  = 5'd18;
  localparam logic [4:0] OP_MTHI  = 5'd19;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t      state;
  logic [5:0]  count;
  logic [63:0] acc;       // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [31:0] opd_r;     // multiplicand or divisor magnitude
  logic [31:0] op1_r;     // raw dividend, needed for divide-by-zero result
  logic        is_mul_r;
  logic        neg_q_r;   // negate product / quotient
  logic        neg_r_r;   // negate remainder
  logic        div_zero_r;

  logic        is_mul, is_sgn, is_md;
  logic [31:0] mag1, mag2;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift, div_diff;
  logic [63:0] div_next;
  logic [63:0] prod_final;

  // Operand decode and one shift-add / restoring-subtract step
  always_comb begin
    is_mul    = (control_alu == OP_MULTU) || (control_alu == OP_MULT);
    is_sgn    = (control_alu == OP_MULT) || (control_alu == OP_DIV);
    is_md     = is_mul || (control_alu == OP_DIVU) || (control_alu == OP_DIV);
    mag1      = (is_sgn && op1[31]) ? (32'd0 - op1) : op1;
    mag2      = (is_sgn && op2[31]) ? (32'd0 - op2) : op2;
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opd_r} : 33'd0);
    mul_next  = {mul_sum, acc[31:1]};
    div_shift = acc[63:31];
    div_diff  = div_shift - {1'b0, opd_r};
    div_next  = div_diff[32] ? {div_shift[31:0], acc[30:0], 1'b0}
                             : {div_diff[31:0], acc[30:0], 1'b1};
    prod_final = neg_q_r ? (64'd0 - acc) : acc;
  end

  // Control FSM, iteration datapath and HI/LO registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= 6'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      HI         <= 32'd0;
      LO         <= 32'd0;
      acc        <= 64'd0;
      opd_r      <= 32'd0;
      op1_r      <= 32'd0;
      is_mul_r   <= 1'b0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && control_alu == OP_MTHI) begin
            HI   <= op1;
            done <= 1'b1;
          end else if (start && control_alu == OP_MTLO) begin
            LO   <= op1;
            done <= 1'b1;
          end else if (start && is_md) begin
            state      <= RUN;
            busy       <= 1'b1;
            count      <= 6'd0;
            is_mul_r   <= is_mul;
            opd_r      <= is_mul ? mag1 : mag2;
            acc        <= is_mul ? {32'd0, mag2} : {32'd0, mag1};
            op1_r      <= op1;
            neg_q_r    <= is_sgn && (op1[31] ^ op2[31]);
            neg_r_r    <= is_sgn && op1[31];
            div_zero_r <= (op2 == 32'd0);
          end
        end
        RUN: begin
          acc   <= is_mul_r ? mul_next : div_next;
          count <= count + 6'd1;
          if (count == 6'd31) state <= FINISH;
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          count <= 6'd0;
          if (is_mul_r) begin
            HI <= prod_final[63:32];
            LO <= prod_final[31:0];
          end else if (div_zero_r) begin
            HI <= op1_r;
            LO <= 32'hFFFF_FFFF;
          end else begin
            HI <= neg_r_r ? (32'd0 - acc[63:32]) : acc[63:32];
            LO <= neg_q_r ? (32'd0 - acc[31:0]) : acc[31:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus_muldiv.sv
// tb/tb_mips_cpu_bus_muldiv.sv - randomized self-checking bench for mips_cpu_bus_muldiv
module tb_mips_cpu_bus_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  control_alu;
  logic [31:0] op1, op2;
  logic        busy, done;
  logic [31:0] HI, LO;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_hi, m_lo;

  mips_cpu_bus_muldiv dut (
    .clk(clk), .reset(reset), .start(start), .control_alu(control_alu),
    .op1(op1), .op2(op2), .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  // Architectural reference: what HI/LO become after an instruction
  function automatic void model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (c)
      5'd7: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      5'd8: begin q = sa * sb; p = q; m_hi = p[63:32]; m_lo = p[31:0]; end
      5'd4: if (b == 0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
            else begin m_lo = a / b; m_hi = a % b; end
      5'd5: if (b == 0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
            else begin q = sa / sb; r = sa % sb; p = q; m_lo = p[31:0]; p = r; m_hi = p[31:0]; end
      5'd18: m_lo = a;
      5'd19: m_hi = a;
      default: ;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; control_alu = 5'd7; op1 = 32'd3; op2 = 32'd4;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    m_hi = 0; m_lo = 0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (HI !== 32'd0) begin miscompares++; $display("FAIL reset_hi got %h want 0", HI); end
    vectors++; if (LO !== 32'd0) begin miscompares++; $display("FAIL reset_lo got %h want 0", LO); end
  endtask

  // Full mul/div transaction with cycle-by-cycle checks; optional start pulse while busy
  task automatic run_md(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b, input bit disturb);
    logic [31:0] old_hi, old_lo;
    old_hi = m_hi; old_lo = m_lo;
    @(negedge clk);
    start = 1'b1; control_alu = c; op1 = a; op2 = b;
    @(posedge clk);
    #1;
    start = 1'b0; op1 = $urandom; op2 = $urandom; control_alu = 5'($urandom_range(0, 31));
    model(c, a, b);
    for (int k = 0; k <= 33; k++) begin
      @(negedge clk);
      if (disturb && k == 9) begin start = 1'b1; control_alu = 5'd5; op1 = 32'h8000_0000; op2 = 32'd3; end
      if (disturb && k == 10) start = 1'b0;
      if (k < 33) begin
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL run_busy op%0d k%0d got %b want 1", c, k, busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL run_done op%0d k%0d got %b want 0", c, k, done); end
        vectors++; if (HI !== old_hi || LO !== old_lo) begin miscompares++;
          $display("FAIL run_hold op%0d k%0d got %h_%h want %h_%h", c, k, HI, LO, old_hi, old_lo); end
      end else begin
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL end_busy op%0d got %b want 0", c, busy); end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL end_done op%0d got %b want 1", c, done); end
        vectors++; if (HI !== m_hi) begin miscompares++; $display("FAIL result_hi op%0d a=%h b=%h got %h want %h", c, a, b, HI, m_hi); end
        vectors++; if (LO !== m_lo) begin miscompares++; $display("FAIL result_lo op%0d a=%h b=%h got %h want %h", c, a, b, LO, m_lo); end
      end
    end
    @(negedge clk);
    vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++;
      $display("FAIL post_idle op%0d got done=%b busy=%b want 0 0", c, done, busy); end
  endtask

  task automatic test_directed();
    run_md(5'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_md(5'd8, 32'hFFFF_FFFD, 32'd5, 1'b0);
    run_md(5'd5, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_md(5'd5, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_md(5'd4, 32'd100, 32'd0, 1'b0);
    run_md(5'd4, 32'd100, 32'd7, 1'b0);
    run_md(5'd5, 32'hFFFF_FF00, 32'd0, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_md(5'd7, 32'd6, 32'd7, 1'b1);
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] old_lo;
    old_lo = m_lo;
    @(negedge clk);
    start = 1'b1; control_alu = 5'd19; op1 = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    control_alu = 5'd18; op1 = 32'h1234_5678;
    @(negedge clk);
    vectors++; if (done !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL mthi_flags got done=%b busy=%b want 1 0", done, busy); end
    vectors++; if (HI !== 32'hDEAD_BEEF || LO !== old_lo) begin miscompares++;
      $display("FAIL mthi_regs got %h_%h want deadbeef_%h", HI, LO, old_lo); end
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    vectors++; if (done !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL mtlo_flags got done=%b busy=%b want 1 0", done, busy); end
    vectors++; if (HI !== 32'hDEAD_BEEF || LO !== 32'h1234_5678) begin miscompares++;
      $display("FAIL mtlo_regs got %h_%h want deadbeef_12345678", HI, LO); end
    @(negedge clk);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL mt_done_end got %b want 0", done); end
    m_hi = 32'hDEAD_BEEF; m_lo = 32'h1234_5678;
  endtask

  task automatic test_ignored_codes();
    logic [4:0] c;
    for (int i = 0; i < 8; i++) begin
      do c = 5'($urandom_range(0, 31)); while (c inside {5'd4, 5'd5, 5'd7, 5'd8, 5'd18, 5'd19});
      @(negedge clk);
      start = 1'b1; control_alu = c; op1 = $urandom; op2 = $urandom;
      @(negedge clk);
      start = 1'b0;
      vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++;
        $display("FAIL ignored_code %0d got done=%b busy=%b want 0 0", c, done, busy); end
      vectors++; if (HI !== m_hi || LO !== m_lo) begin miscompares++;
        $display("FAIL ignored_regs %0d got %h_%h want %h_%h", c, HI, LO, m_hi, m_lo); end
    end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    start = 1'b1; control_alu = 5'd4; op1 = 32'd1000; op2 = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 14; k++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 0; m_lo = 0;
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++;
      $display("FAIL abort_flags got busy=%b done=%b want 0 0", busy, done); end
    vectors++; if (HI !== 32'd0 || LO !== 32'd0) begin miscompares++;
      $display("FAIL abort_regs got %h_%h want 0_0", HI, LO); end
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++;
        $display("FAIL abort_quiet k%0d got done=%b busy=%b want 0 0", k, done, busy); end
    end
    run_md(5'd7, 32'd2, 32'd3, 1'b0);
  endtask

  task automatic test_random();
    logic [4:0] codes [4] = '{5'd4, 5'd5, 5'd7, 5'd8};
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 1000)));
      run_md(codes[$urandom_range(0, 3)], a, b, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; control_alu = 5'd0; op1 = 32'd0; op2 = 32'd0;
    m_hi = 0; m_lo = 0;
    test_reset();
    test_directed();
    test_start_while_busy();
    test_mthi_mtlo();
    test_ignored_codes();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_cpu_bus_muldiv.md
MIPS_CPU_BUS_MULDIV -- requirements
Module: mips_cpu_bus_muldiv

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Port list SHALL be as follows (clock and reset first):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- start  in  1  request strobe, sampled on rising edge of clk
- control_alu  in  5  operation code: 4 DIVU, 5 DIV, 7 MULTU, 8 MULT, 18 MTLO, 19 MTHI
- op1  in  32  rs value: dividend, multiplicand, or MTHI/MTLO source
- op2  in  32  rt value: divisor or multiplier
- busy  out  1  high while a multiply or divide is in progress
- done  out  1  one-cycle completion pulse
- HI  out  32  HI register, driven directly from a flop
- LO  out  32  LO register, driven directly from a flop

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, RUN and FINISH.
REQ-004 Accepted request: in IDLE, a request SHALL be accepted only when start=1 and control_alu is in {4,5,7,8,18,19}.
REQ-005 Ignored requests: any other code with start=1 SHALL be ignored, with no state change and no done pulse.
REQ-006 Start while busy: start SHALL be ignored in RUN and FINISH.
REQ-007 Operand capture: on acceptance, op1, op2 and the operation SHALL be latched, and later input changes SHALL have no effect on the result.
REQ-008 MTHI/MTLO timing: on the acceptance edge, HI (code 19) or LO (code 18) SHALL be loaded with op1, the other register SHALL be unchanged, the FSM SHALL stay in IDLE, and done SHALL be 1 for the following cycle.
REQ-009 MTHI/MTLO busy: busy SHALL remain 0 throughout an MTHI/MTLO.
REQ-010 Mul/div acceptance: when a mul/div is accepted at edge E0, the FSM SHALL go to RUN and busy SHALL be 1 from E0 onward.
REQ-011 RUN duration: RUN SHALL last exactly 32 cycles (edges E1..E32), performing one iteration per edge.
REQ-012 RUN sequencing: RUN SHALL use a 6-bit iteration counter, SHALL go to FINISH after iteration 32, and SHALL be bit-serial (not a single-cycle `*` or `/`).
REQ-013 FINISH: at edge E33 the FSM SHALL write HI and LO, return to IDLE, drive busy=0, and drive done=1 for exactly the cycle after E33.
REQ-014 Latency: total mul/div latency SHALL be 33 cycles, start edge to result edge.
REQ-015 HI/LO during operation: HI and LO SHALL hold their previous values throughout RUN.
REQ-016 MULTU: {HI,LO} SHALL equal the unsigned 64-bit product op1*op2, computed by shift-add.
REQ-017 MULT: operands SHALL be converted to magnitudes, multiplied unsigned, and the 64-bit product two's-complement negated in FINISH when op1[31]^op2[31]=1.
REQ-018 DIVU: the divider SHALL be restoring, with LO = quotient and HI = remainder (unsigned).
REQ-019 DIV: the block SHALL divide magnitudes, then negate LO when op1[31]^op2[31]=1 and negate HI when op1[31]=1, truncating toward zero.
REQ-020 DIV overflow: 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0x00000000, with no exception.
REQ-021 Divide by zero (DIV or DIVU): the block SHALL still take 33 cycles, then write HI=op1 (as latched) and LO=0xFFFFFFFF.

Reset
REQ-022 Reset values: reset=1 at a rising edge SHALL force IDLE, busy=0, done=0, HI=0x00000000, LO=0x00000000, and counter=0.
REQ-023 Reset mid-operation: reset SHALL take priority over start and over any in-flight operation, aborting it with no done pulse and no partial HI/LO write.
REQ-024 Outputs from reset until the first completed operation: HI, LO, busy and done SHALL hold their reset values.

Verification
REQ-025 MULTU: 0xFFFFFFFF * 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; done exactly 34 cycles after start cycle begins (pulse after E33); busy high 33 cycles.
REQ-026 MULT and DIV signed cases:
- MULT -3 * 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-027 DIVU 0x00000064 / 0 -> HI=0x00000064, LO=0xFFFFFFFF after 33 cycles; DIVU 100/7 -> LO=14, HI=2.
REQ-028 Start during busy and input changes: issue MULTU 6*7, then pulse start with DIV at cycle 10 and change op1/op2 -> second request ignored; HI=0, LO=42; a single done pulse.
REQ-029 Reset mid-operation: reset asserted at cycle 15 of a DIVU -> next cycle busy=0, HI=LO=0, no done pulse; a fresh MULTU 2*3 afterwards gives LO=6.
REQ-030 MTHI 0xDEADBEEF, then MTLO 0x12345678 on consecutive cycles -> HI=0xDEADBEEF, LO=0x12345678; done high for two consecutive cycles; busy never high.
